norm_shift_unit: RTL and testbench
==================================

# norm_shift_unit

Parametrised successor to the single-width normalize/shift controller. It merges the control FSM and the datapath into one block with WIDTH-bit operands and three operating modes: left-normalize with leading-zero count, right-shift by a requested amount, or both in sequence. It also reports zero-operand detection and exposes a busy/done handshake. It sits between the operand register file and the arithmetic stage that consumes normalized mantissas.

## Interface
- WIDTH, 16: operand/result width in bits (≥2).
- CW, $clog2(WIDTH+1): width of count fields; must hold the value WIDTH.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request. Sampled only in IDLE.
- mode  in  2  operation select, captured with start:
  - 0: normalize.
  - 1: right-shift.
  - 2: normalize then right-shift.
  - 3: same as 0.
- din  in  WIDTH  operand, captured with start.
- amt  in  CW  right-shift amount, captured with start.
- busy  out  1  high in INIT, COUNT, LOAD and SHIFT.
- done  out  1  one-cycle pulse in DONE.
- dout  out  WIDTH  result register; holds its value until the next capture.
- lzc  out  CW  leading-zero count from the last normalize. 0 when mode=1.
- zero_in  out  1  captured operand was all zeros.

## Operation
- **Reset:** state IDLE. dout, lzc, zero_in, busy and done are all 0. Internal counters are 0.
- **IDLE:** when start=1, capture din into the data register, mode, amt (saturated to WIDTH if greater), and zero_in=(din==0). Clear lzc to 0. Go to INIT. Otherwise stay in IDLE.
- **INIT:** stay while start=1 (start-release wait). Once start=0:
  - mode 1: go to LOAD.
  - all other modes: go to COUNT.
- **COUNT:** each cycle, if data==0, or data[WIDTH-1]==1, or lzc==WIDTH, exit:
  - to LOAD if mode 2;
  - otherwise to DONE.
  - Else shift data left one bit (zero fill) and increment lzc.
- **Zero operand in COUNT:** lzc is set directly to WIDTH on the first COUNT cycle, and COUNT exits that same cycle.
- **LOAD:** load shift counter sc=amt_sat. Go to DONE if amt_sat==0, else to SHIFT.
- **SHIFT:** each cycle, logical shift data right one bit and decrement sc. Go to DONE on the cycle where sc==1 before the decrement.
- **DONE:** done=1 for exactly one cycle, then unconditionally to IDLE. A start seen in DONE is ignored.
- dout is continuously driven from the data register, so its final value is stable from DONE onward.
- Arithmetic:
  - all shifts are logical;
  - lzc ranges 0..WIDTH and never wraps;
  - sc is unsigned CW bits and never underflows.
- start while busy is ignored. Inputs other than start are don't-care outside the IDLE capture cycle.
- Async reset mid-operation returns to IDLE with all outputs cleared within the same cycle. No done pulse is produced for the aborted operation.

## Timing
- Cycle 0 = the IDLE cycle in which start=1 is sampled. Let h = number of consecutive start-high cycles (h ≥ 1).
- INIT occupies h cycles when start is held (1 cycle for a single-cycle pulse).
- COUNT occupies lzc+1 cycles for a nonzero operand, and 1 cycle for a zero operand.
- LOAD occupies 1 cycle. SHIFT occupies amt_sat cycles.
- done cycle:
  - mode 0: h+lzc+1
  - mode 1: h+1+amt_sat
  - mode 2: h+lzc+2+amt_sat
  - For a zero operand, substitute 0 for lzc in these formulas.
- The earliest new start is accepted in the cycle after done, i.e. back in IDLE.
- All outputs are registered or decoded from the state register. There are no combinational input-to-output paths.

## Test plan
- WIDTH=8, din=0x13, mode=0, 1-cycle start → dout=0x98, lzc=3, zero_in=0, done at cycle 5.
- din=0xF0, mode=1, amt=3 → dout=0x1E, lzc=0, done at cycle 5. Repeat with amt=0 → dout=0xF0, done at cycle 2.
- din=0x05, mode=2, amt=2 → dout=0x28, lzc=5, done at cycle 10. Repeat with start held 3 cycles → done at cycle 12.
- din=0x00, mode=2, amt=12 → lzc=8, zero_in=1, dout=0x00, sc saturates to 8, done at cycle 11.
- Assert rst mid-SHIFT → busy=0, done=0, dout=0 immediately. A fresh din=0x80, mode=0 then gives lzc=0, dout=0x80, done at cycle 2.
- Pulse start while busy and while in DONE → operation unaffected. No second capture occurs, and the result matches the single-request case.

Source files
------------

// File: rtl/norm_shift_unit.sv
// norm_shift_unit
//   Combined normalize / right-shift controller and datapath. Captures an
//   operand on start, optionally left-normalizes it while counting leading
//   zeros, optionally right-shifts it by a saturated amount, then pulses done.
//
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   start   : request, sampled only in IDLE
//   mode    : 0/3 normalize, 1 right-shift, 2 normalize then right-shift
//   din     : operand, captured with start
//   amt     : right-shift amount, captured with start (saturated to WIDTH)
//   busy    : high in INIT, COUNT, LOAD, SHIFT
//   done    : one-cycle pulse in DONE
//   dout    : result register
//   lzc     : leading-zero count from the last normalize (0 for mode 1)
//   zero_in : captured operand was all zeros
//
// State    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; captures operand, mode and amount
// S_INIT   | waiting for start to be released
// S_COUNT  | shifting left one bit per cycle until MSB set or operand zero
// S_LOAD   | loading the shift counter from the saturated amount
// S_SHIFT  | shifting right one bit per cycle until the counter expires
// S_DONE   | one-cycle completion pulse
module norm_shift_unit #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic [CW-1:0]    amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    lzc,
  output logic             zero_in
);

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_COUNT = 3'd2,
    S_LOAD  = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [1:0]       mode_q,  mode_d;
  logic [CW-1:0]    amt_q,   amt_d;
  logic [CW-1:0]    sc_q,    sc_d;
  logic [CW-1:0]    lzc_q,   lzc_d;
  logic             zero_q,  zero_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      mode_q  <= '0;
      amt_q   <= '0;
      sc_q    <= '0;
      lzc_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      amt_q   <= amt_d;
      sc_q    <= sc_d;
      lzc_q   <= lzc_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    amt_d   = amt_q;
    sc_d    = sc_q;
    lzc_d   = lzc_q;
    zero_d  = zero_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = din;
          mode_d  = mode;
          amt_d   = (amt > WIDTH_C) ? WIDTH_C : amt;
          zero_d  = (din == '0);
          lzc_d   = '0;
          state_d = S_INIT;
        end
      end

      S_INIT: begin
        if (!start) begin
          state_d = (mode_q == 2'd1) ? S_LOAD : S_COUNT;
        end
      end

      S_COUNT: begin
        // A zero operand never reaches an MSB, so report the full width at once.
        if (data_q == '0) begin
          lzc_d   = WIDTH_C;
          state_d = (mode_q == 2'd2) ? S_LOAD : S_DONE;
        end else if (data_q[WIDTH-1] || (lzc_q == WIDTH_C)) begin
          state_d = (mode_q == 2'd2) ? S_LOAD : S_DONE;
        end else begin
          data_d = {data_q[WIDTH-2:0], 1'b0};
          lzc_d  = lzc_q + ONE_C;
        end
      end

      S_LOAD: begin
        sc_d    = amt_q;
        state_d = (amt_q == '0) ? S_DONE : S_SHIFT;
      end

      S_SHIFT: begin
        data_d = {1'b0, data_q[WIDTH-1:1]};
        if (sc_q != '0) begin
          sc_d = sc_q - ONE_C;
        end
        // The <= also covers a zero counter so the state can never stick here.
        if (sc_q <= ONE_C) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q == S_INIT) || (state_q == S_COUNT) ||
                   (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign done    = (state_q == S_DONE);
  assign dout    = data_q;
  assign lzc     = lzc_q;
  assign zero_in = zero_q;

endmodule

// File: tb/tb_norm_shift_unit.sv
module tb_norm_shift_unit;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [W-1:0]  din;
  logic [CW-1:0] amt;
  logic          busy;
  logic          done;
  logic [W-1:0]  dout;
  logic [CW-1:0] lzc;
  logic          zero_in;

  int errors;
  int checks;

  norm_shift_unit #(.WIDTH(W), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .din     (din),
    .amt     (amt),
    .busy    (busy),
    .done    (done),
    .dout    (dout),
    .lzc     (lzc),
    .zero_in (zero_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: leading zeros from the operand's bit length, results by
  // multiplication/division, latency from the per-mode phase durations.
  function automatic void ref_model(input int d, input int m, input int a, input int h,
                                    output int e_dout, output int e_lzc,
                                    output int e_zero, output int e_lat);
    int bits, v, lz, lz_time, sat, norm;
    bits = 0;
    v = d;
    while (v > 0) begin
      v = v / 2;
      bits++;
    end
    lz      = W - bits;
    lz_time = (d == 0) ? 0 : lz;
    sat     = (a > W) ? W : a;
    norm    = (d * (1 << lz)) % (1 << W);
    e_zero  = (d == 0) ? 1 : 0;
    case (m)
      1: begin
        e_dout = d / (1 << sat);
        e_lzc  = 0;
        e_lat  = h + 1 + sat;
      end
      2: begin
        e_dout = norm / (1 << sat);
        e_lzc  = lz;
        e_lat  = h + lz_time + 2 + sat;
      end
      default: begin
        e_dout = norm;
        e_lzc  = lz;
        e_lat  = h + lz_time + 1;
      end
    endcase
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  // poke: pulse start during the busy phase and again in DONE, and scramble
  // the data inputs after capture; none of that may affect the result.
  task automatic run_op(input int d, input int m, input int a, input int h,
                        input bit poke, input string name);
    int e_dout, e_lzc, e_zero, e_lat;
    int j;
    bit seen, busy_ok;
    ref_model(d, m, a, h, e_dout, e_lzc, e_zero, e_lat);
    start = 1'b1;
    din   = W'(d);
    mode  = 2'(m);
    amt   = CW'(a);
    @(posedge clk);
    j = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (!seen && j < 200) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (!busy) busy_ok = 1'b0;
        start = (j < h - 1) || (poke && j == h);
        if (poke && j == 0) begin
          din  = ~W'(d);
          mode = ~2'(m);
          amt  = ~CW'(a);
        end
        @(posedge clk);
        j++;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: no done within %0d cycles, required at %0d", name, j, e_lat);
    end else begin
      checks++;
      if (j != e_lat) begin
        errors++;
        $display("FAIL %s done_latency: got %0d required %0d", name, j, e_lat);
      end
      checks++;
      if (dout !== W'(e_dout)) begin
        errors++;
        $display("FAIL %s dout: got 0x%0h required 0x%0h", name, dout, e_dout);
      end
      checks++;
      if (lzc !== CW'(e_lzc)) begin
        errors++;
        $display("FAIL %s lzc: got %0d required %0d", name, lzc, e_lzc);
      end
      checks++;
      if (zero_in !== 1'(e_zero)) begin
        errors++;
        $display("FAIL %s zero_in: got %0b required %0b", name, zero_in, e_zero);
      end
      checks++;
      if (!busy_ok || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_window: got busy_ok=%0b busy_in_done=%0b required 1/0", name, busy_ok, busy);
      end
    end
    start = poke;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || dout !== W'(e_dout)) begin
      errors++;
      $display("FAIL %s after_done: got done=%0b busy=%0b dout=0x%0h required 0/0/0x%0h",
               name, done, busy, dout, e_dout);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    mode  = '0;
    din   = '0;
    amt   = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== '0 || lzc !== '0 || zero_in !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got busy=%0b done=%0b dout=0x%0h lzc=%0d zero_in=%0b required all 0",
               busy, done, dout, lzc, zero_in);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(8'h13, 0, 0, 1, 1'b0, "norm_0x13");
    run_op(8'hF0, 1, 3, 1, 1'b0, "rshift_amt3");
    run_op(8'hF0, 1, 0, 1, 1'b0, "rshift_amt0");
    run_op(8'h05, 2, 2, 1, 1'b0, "both_0x05");
    run_op(8'h05, 2, 2, 3, 1'b0, "both_0x05_hold3");
    run_op(8'h00, 2, 12, 1, 1'b0, "zero_sat");
    run_op(8'h00, 0, 0, 2, 1'b0, "zero_norm");
    run_op(8'h01, 3, 0, 1, 1'b0, "mode3_0x01");
    run_op(8'hFF, 1, 8, 1, 1'b0, "rshift_full");
  endtask

  task automatic test_mid_shift_reset();
    int j;
    bit done_seen;
    start = 1'b1;
    din   = 8'hF0;
    mode  = 2'd1;
    amt   = CW'(8);
    @(posedge clk);
    done_seen = 1'b0;
    for (j = 0; j < 3; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) done_seen = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (done_seen || busy !== 1'b0 || done !== 1'b0 || dout !== '0 || lzc !== '0 || zero_in !== 1'b0) begin
      errors++;
      $display("FAIL mid_shift_reset: got early_done=%0b busy=%0b done=%0b dout=0x%0h lzc=%0d zero_in=%0b required all 0",
               done_seen, busy, done, dout, lzc, zero_in);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(8'h80, 0, 0, 1, 1'b0, "after_reset_0x80");
  endtask

  task automatic test_busy_and_done_pulses();
    run_op(8'h13, 0, 0, 1, 1'b1, "poke_norm");
    run_op(8'h05, 2, 2, 1, 1'b1, "poke_both");
    run_op(8'hF0, 1, 3, 2, 1'b1, "poke_rshift");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      int d, m, a, h;
      bit p;
      d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      m = int'($urandom_range(0, 3));
      a = int'($urandom_range(0, 15));
      h = int'($urandom_range(1, 3));
      p = 1'($urandom_range(0, 1));
      run_op(d, m, a, h, p, $sformatf("rand%0d_d%0h_m%0d_a%0d_h%0d", i, d, m, a, h));
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_directed();
    test_mid_shift_reset();
    test_busy_and_done_pulses();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
